// File: rtl/timer_unit.sv
// Three-channel countdown timer (alarm, pulse gate, periodic strobe) armed from one load bus.
// Optional build macro TIMER_STICKY_BELL_EN: bell latches on expiry until the next put or reset.
module timer_unit #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] value,
  input  logic         put,
  output logic         bell,
  output logic         act,
  output logic         beep
);

  localparam logic [W-1:0] ZERO = {W{1'b0}};
  localparam logic [W-1:0] ONE  = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] c_q, c_d;
  logic [W-1:0] s_q, s_d;
  logic         r_q, r_d;
  logic         bell_q, bell_d;
  logic         act_q;
  logic         beep_q, beep_d;

  // Alarm/pulse counter: load on put, otherwise count down to zero and hold.
  always_comb begin
    c_d = c_q;
    if (put) begin
      c_d = value;
    end else if (c_q != ZERO) begin
      c_d = c_q - ONE;
    end else begin
      c_d = c_q;
    end
  end

  // Expiry is the 1->0 step of C; a put on that edge aborts the count, so no bell.
  always_comb begin
    bell_d = 1'b0;
`ifdef TIMER_STICKY_BELL_EN
    if (put) begin
      bell_d = 1'b0;
    end else begin
      bell_d = bell_q | (c_q == ONE);
    end
`else
    if (put) begin
      bell_d = 1'b0;
    end else begin
      bell_d = (c_q == ONE);
    end
`endif
  end

  // Strobe counter: period end reloads from the live value, so a new value applies next period.
  always_comb begin
    s_d    = s_q;
    r_d    = r_q;
    beep_d = 1'b0;
    if (put) begin
      s_d = value;
      r_d = (value != ZERO);
    end else if (r_q && (s_q == ONE)) begin
      s_d    = value;
      r_d    = (value != ZERO);
      beep_d = 1'b1;
    end else if (r_q && (s_q != ZERO)) begin
      s_d = s_q - ONE;
    end else begin
      s_d = s_q;
    end
  end

  // State and registered outputs; act follows the next value of C so it rises right after put.
  always_ff @(posedge clock) begin
    if (reset) begin
      c_q    <= ZERO;
      s_q    <= ZERO;
      r_q    <= 1'b0;
      bell_q <= 1'b0;
      act_q  <= 1'b0;
      beep_q <= 1'b0;
    end else begin
      c_q    <= c_d;
      s_q    <= s_d;
      r_q    <= r_d;
      bell_q <= bell_d;
      act_q  <= (c_d != ZERO);
      beep_q <= beep_d;
    end
  end

  assign bell = bell_q;
  assign act  = act_q;
  assign beep = beep_q;

endmodule

// File: tb/tb_timer_unit.sv
// Directed bench for timer_unit: an event-time reference model pushes expected outputs per edge,
// which are popped and compared half a cycle later.
module tb_timer_unit;

  logic       clock;
  logic       reset;
  logic [7:0] value;
  logic       put;
  logic       bell;
  logic       act;
  logic       beep;

  int checks = 0;
  int errors = 0;

  int e         = 0;
  int act_until = 0;
  int bell_at   = -1;
  int beep_at   = -1;
  bit latched   = 1'b0;

  logic [2:0] exp_q[$];

  timer_unit #(.W(8)) dut (
    .clock (clock),
    .reset (reset),
    .value (value),
    .put   (put),
    .bell  (bell),
    .act   (act),
    .beep  (beep)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s edge=%0d observed=%b expected=%b", tag, e, obs, expv);
    end
  endtask

  // One clock: drive inputs, model the edge, then compare at the following negedge.
  task automatic step(input logic rst, input logic p, input logic [7:0] v);
    logic eb, ea, ebp;
    logic [2:0] got;
    reset = rst;
    put   = p;
    value = v;
    @(posedge clock);
    e++;
    eb = 1'b0; ea = 1'b0; ebp = 1'b0;
    if (rst) begin
      act_until = e;
      bell_at   = -1;
      beep_at   = -1;
      latched   = 1'b0;
    end else begin
      ebp = (!p && (e == beep_at));
      if (p) begin
        act_until = e + int'(v);
        bell_at   = (v != 8'd0) ? e + int'(v) : -1;
        beep_at   = (v != 8'd0) ? e + int'(v) : -1;
        latched   = 1'b0;
      end else if (ebp) begin
        beep_at = (v != 8'd0) ? e + int'(v) : -1;
      end
      eb = (e == bell_at);
`ifdef TIMER_STICKY_BELL_EN
      latched = latched | eb;
      eb = latched;
`endif
      ea = (e < act_until);
    end
    exp_q.push_back({eb, ea, ebp});
    @(negedge clock);
    got = exp_q.pop_front();
    chk("bell", bell, got[2]);
    chk("act",  act,  got[1]);
    chk("beep", beep, got[0]);
  endtask

  task automatic idle(input int n, input logic [7:0] v);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, v);
  endtask

  initial begin
    reset = 1'b1;
    put   = 1'b0;
    value = 8'd0;
    // reset then quiet
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'd0);
    idle(20, 8'd0);
    // single load of 0x11: act 17 cycles, bell once, beeps every 17
    step(1'b0, 1'b1, 8'h11);
    idle(40, 8'h11);
    // retrigger three cycles after the first put
    step(1'b0, 1'b1, 8'h11);
    idle(2, 8'h11);
    step(1'b0, 1'b1, 8'h11);
    idle(25, 8'h11);
    // value change without put applies at the next reload
    step(1'b0, 1'b1, 8'h11);
    idle(3, 8'h11);
    idle(40, 8'h07);
    // cancel everything with put of zero
    step(1'b0, 1'b1, 8'h11);
    idle(5, 8'h11);
    step(1'b0, 1'b1, 8'h00);
    idle(30, 8'h11);
    // reset mid-count
    step(1'b0, 1'b1, 8'h11);
    idle(5, 8'h11);
    step(1'b1, 1'b0, 8'h11);
    idle(30, 8'h11);
    // expiry then reset (clears a latched bell), expiry then put of zero
    step(1'b0, 1'b1, 8'h05);
    idle(8, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    idle(3, 8'h00);
    step(1'b0, 1'b1, 8'h03);
    idle(6, 8'h00);
    step(1'b0, 1'b1, 8'h00);
    idle(3, 8'h00);
    // put on the expiry edge wins
    step(1'b0, 1'b1, 8'h04);
    idle(3, 8'h00);
    step(1'b0, 1'b1, 8'h02);
    idle(5, 8'h00);
    // value 1: beep every cycle
    step(1'b0, 1'b1, 8'h01);
    idle(6, 8'h01);
    step(1'b0, 1'b1, 8'h00);
    idle(2, 8'h00);
    // put held for three edges
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h05);
    idle(10, 8'h05);
    // maximum count
    step(1'b0, 1'b1, 8'hFF);
    idle(260, 8'hFF);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
